mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares the single-port byte memory (2**`WIDTH_DOUBLE x 8) between the core's
//   instruction-fetch port and its data load/store port. Sequences the two byte
//   reads of a 16-bit op fetch, returns little-endian {mem[a+1],mem[a]}, and
//   arbitrates when both ports request. Sits between the core FSM and the memory array.
// PARAMETERS
//   AW  `WIDTH_DOUBLE (16)  address width; all address arithmetic is mod 2**AW
//   DW  `WIDTH_WORD (8)     memory data width; fetch response is 2*DW
// PORTS
//   clk          in   1     system clock, all logic on posedge
//   rst_n        in   1     synchronous reset, active low
//   if_req_valid in   1     fetch request; hold it and if_addr stable until accepted
//   if_req_ready out  1     fetch request accepted when valid&&ready
//   if_addr      in   AW    fetch address (low byte)
//   if_rsp_valid out  1     one-cycle pulse: if_rsp_data valid
//   if_rsp_data  out  2*DW  {mem[a+1],mem[a]}; held until the next fetch response
//   d_req_valid  in   1     data request; hold it and its fields stable until accepted
//   d_req_ready  out  1     data request accepted when valid&&ready
//   d_we         in   1     1=store, 0=load
//   d_addr       in   AW    data address
//   d_wdata      in   DW    store data
//   d_rsp_valid  out  1     one-cycle pulse: load data or store ack
//   d_rsp_data   out  DW    load data; unchanged on a store ack
//   mem_en       out  1     memory access strobe
//   mem_we       out  1     memory write enable (only with mem_en)
//   mem_addr     out  AW    memory address
//   mem_wdata    out  DW    memory write data
//   mem_rdata    in   DW    read data, valid the cycle after mem_en&&!mem_we
//   busy         out  1     state != IDLE
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): state IDLE; all outputs 0; in-flight op dropped, no
//   response ever issued for it; RR pointer cleared (fetch wins the first conflict).
//   FSM states (`MARB_ST_*): IDLE, F_LO, F_HI, F_WAIT, D_ACC, D_WAIT.
//   IDLE: readys are combinational from state and valids; at most one ready high;
//     neither high outside IDLE. Accept at cycle T latches addr/we/wdata.
//   Fetch: F_LO (T+1) mem_en, addr=a; F_HI (T+2) mem_en, addr=a+1, lo<=mem_rdata;
//     F_WAIT (T+3) if_rsp_data<={mem_rdata,lo}, if_rsp_valid<=1 -> pulse seen at T+4.
//     a=16'hFFFF: second byte read from 16'h0000 (wrap).
//   Load: D_ACC (T+1) mem_en, addr; D_WAIT (T+2) d_rsp_data<=mem_rdata -> pulse T+3.
//   Store: D_ACC (T+1) mem_en, mem_we, addr, wdata; ack pulse T+2, no D_WAIT.
//   F_WAIT/D_WAIT/store-D_ACC return to IDLE; a new request may be accepted in the
//   cycle the response pulse is visible (back-to-back: fetch every 4, load every 3).
//   mem_* outputs are 0 in every cycle without an access (no stray strobes).
//   Arbitration in IDLE with both valids: see CONFIGURATION. Single valid: granted.
//   Request dropped before acceptance: no effect. Valids ignored while busy.
// CONFIGURATION
//   MEM_ARB_RR_EN defined: round-robin; 1-bit last-grant pointer updated on every
//     accept; on conflict the port not granted last wins. No port waits >1 op.
//   Not defined: fixed priority, data port always wins the conflict (fetch may
//     starve under continuous data traffic; core FSM never does this).
// STRUCTURE
//   const.v: `WIDTH_DOUBLE, `WIDTH_WORD, new `MARB_ST_* state codes (3-bit).
//   Single module; no sub-module (grant logic is a few lines, kept inline).
// TESTING
//   mem[0x10]=0x34, mem[0x11]=0x12; fetch 0x0010 at T -> if_rsp_valid at T+4, data 0x1234.
//   mem[0xFFFF]=0xAB, mem[0x0000]=0xCD; fetch 0xFFFF -> 0xCDAB (wrap).
//   Store 0x5A to 0x0200 (ack T+2, mem_we one cycle), then load 0x0200 -> 0x5A at T+3.
//   Both valid in IDLE x3 ops: no RR -> D,D,D; RR -> F,D,F; readys never both high.
//   rst_n low during F_HI -> no if_rsp_valid; next cycle all outputs 0, busy 0;
//     new fetch after reset returns correct data.
//   Continuous checker: mem_en=0 outside access states; rsp pulses exactly 1 cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared widths and FSM state encoding for mem_arbiter.
//               AW = address width (all address arithmetic wraps mod 2**AW),
//               DW = memory data width (fetch response is 2*DW).
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int AW = 16;
    localparam int DW = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_F_LO   = 3'd1,
        ST_F_HI   = 3'd2,
        ST_F_WAIT = 3'd3,
        ST_D_ACC  = 3'd4,
        ST_D_WAIT = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares a single-port byte memory between the instruction
//               fetch port (16-bit little-endian op fetch, two byte reads)
//               and the data load/store port.
// Config      : MEM_ARB_RR_EN defined   -> round-robin on request conflict
//               MEM_ARB_RR_EN undefined -> data port always wins a conflict
// Ports       : clk, rst_n (sync, active low)
//               if_req_valid/if_req_ready/if_addr      fetch request
//               if_rsp_valid/if_rsp_data               fetch response pulse
//               d_req_valid/d_req_ready/d_we/d_addr/d_wdata  data request
//               d_rsp_valid/d_rsp_data                 load data / store ack
//               mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory side
//               busy                                   FSM not idle
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [AW-1:0]     if_addr,
    output logic              if_rsp_valid,
    output logic [2*DW-1:0]   if_rsp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    output logic              d_rsp_valid,
    output logic [DW-1:0]     d_rsp_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic              busy
);

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_addr;
    logic            r_we;
    logic [DW-1:0]   r_wdata;
    logic [DW-1:0]   r_lo;
    logic            w_grant_f;
    logic            w_grant_d;

`ifdef MEM_ARB_RR_EN
    // 1 = fetch was the last port granted; cleared so fetch wins the first conflict
    logic            r_last_f;
`endif

    // Grant logic: only in IDLE, at most one port granted
    always_comb begin
        w_grant_f = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == ST_IDLE) begin
            if (if_req_valid && d_req_valid) begin
`ifdef MEM_ARB_RR_EN
                w_grant_f = !r_last_f;
                w_grant_d = r_last_f;
`else
                w_grant_d = 1'b1;
`endif
            end else begin
                w_grant_f = if_req_valid;
                w_grant_d = d_req_valid;
            end
        end
    end

    assign if_req_ready = w_grant_f;
    assign d_req_ready  = w_grant_d;
    assign busy         = (r_state != ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and memory strobes; mem_* stay zero outside access states
    always_comb begin
        w_next    = r_state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_f) begin
                    w_next = ST_F_LO;
                end else if (w_grant_d) begin
                    w_next = ST_D_ACC;
                end
            end
            ST_F_LO: begin
                mem_en   = 1'b1;
                mem_addr = r_addr;
                w_next   = ST_F_HI;
            end
            ST_F_HI: begin
                mem_en   = 1'b1;
                mem_addr = r_addr + AW'(1);   // wraps FFFF -> 0000
                w_next   = ST_F_WAIT;
            end
            ST_F_WAIT: begin
                w_next = ST_IDLE;
            end
            ST_D_ACC: begin
                mem_en    = 1'b1;
                mem_we    = r_we;
                mem_addr  = r_addr;
                mem_wdata = r_we ? r_wdata : '0;
                // Stores complete here; loads need one more cycle for read data
                w_next    = r_we ? ST_IDLE : ST_D_WAIT;
            end
            ST_D_WAIT: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Request capture and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_lo         <= '0;
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            d_rsp_valid  <= 1'b0;
            d_rsp_data   <= '0;
`ifdef MEM_ARB_RR_EN
            r_last_f     <= 1'b0;
`endif
        end else begin
            if_rsp_valid <= 1'b0;
            d_rsp_valid  <= 1'b0;

            if (w_grant_f) begin
                r_addr <= if_addr;
                r_we   <= 1'b0;
            end else if (w_grant_d) begin
                r_addr  <= d_addr;
                r_we    <= d_we;
                r_wdata <= d_wdata;
            end

`ifdef MEM_ARB_RR_EN
            if (w_grant_f || w_grant_d) begin
                r_last_f <= w_grant_f;
            end
`endif

            case (r_state)
                ST_F_HI: begin
                    // Read data of the low-byte access issued in F_LO
                    r_lo <= mem_rdata;
                end
                ST_F_WAIT: begin
                    if_rsp_data  <= {mem_rdata, r_lo};
                    if_rsp_valid <= 1'b1;
                end
                ST_D_ACC: begin
                    if (r_we) begin
                        d_rsp_valid <= 1'b1;
                    end
                end
                ST_D_WAIT: begin
                    d_rsp_data  <= mem_rdata;
                    d_rsp_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a byte memory model,
//               response scoreboards and continuous protocol checks.
//               Build with MEM_ARB_RR_EN to exercise the round-robin variant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_req_valid;
    logic              if_req_ready;
    logic [AW-1:0]     if_addr;
    logic              if_rsp_valid;
    logic [2*DW-1:0]   if_rsp_data;
    logic              d_req_valid;
    logic              d_req_ready;
    logic              d_we;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic              d_rsp_valid;
    logic [DW-1:0]     d_rsp_data;
    logic              mem_en;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata = '0;
    logic              busy;

    always #5 clk = ~clk;

    mem_arbiter u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_addr      (if_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_we         (d_we),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .busy         (busy)
    );

    // Byte memory model: synchronous read, data valid the cycle after mem_en
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t q_f[$];
    exp_t q_d[$];
    exp_t e_mon;

    int          n_total = 0;
    int          n_pass  = 0;
    int          we_cnt  = 0;
    logic        prev_if = 1'b0;
    logic        prev_d  = 1'b0;
    logic [7:0]  last_d  = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    // Scoreboard pop and continuous protocol checks
    always @(negedge clk) begin
        if (rst_n) begin
            if (if_rsp_valid) begin
                check("if pulse width", {31'd0, prev_if}, 0);
                if (q_f.size() == 0) begin
                    check("if rsp unexpected", {31'd0, if_rsp_valid}, 0);
                end else begin
                    e_mon = q_f.pop_front();
                    check("if rsp data", {16'd0, if_rsp_data}, {16'd0, e_mon.data});
                    check("if rsp cycle", cyc, e_mon.cyc);
                end
            end
            if (d_rsp_valid) begin
                check("d pulse width", {31'd0, prev_d}, 0);
                if (q_d.size() == 0) begin
                    check("d rsp unexpected", {31'd0, d_rsp_valid}, 0);
                end else begin
                    e_mon = q_d.pop_front();
                    check("d rsp data", {24'd0, d_rsp_data}, {16'd0, e_mon.data});
                    check("d rsp cycle", cyc, e_mon.cyc);
                end
            end
            if (if_req_ready || d_req_ready)
                check("ready exclusive", {31'd0, if_req_ready & d_req_ready}, 0);
            if (mem_en)
                check("mem_en only when busy", {31'd0, busy}, 1);
            else
                check("mem quiet when idle", {7'd0, mem_we, mem_addr, mem_wdata}, 0);
            if (mem_we) we_cnt++;
        end
        prev_if = if_rsp_valid;
        prev_d  = d_rsp_valid;
    end

    task automatic do_reset(input int n);
        @(negedge clk);
        rst_n        = 1'b0;
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        repeat (n) @(negedge clk);
        #1;
        check("rst outputs", {if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid,
                              mem_en, mem_we, busy}, 0);
        check("rst rsp data", {8'd0, if_rsp_data, d_rsp_data}, 0);
        check("rst mem bus", {mem_addr, mem_wdata}, 0);
        q_f.delete();
        q_d.delete();
        last_d = 8'h00;
        rst_n  = 1'b1;
    endtask

    task automatic do_fetch(input logic [15:0] a, input logic [15:0] expv, output int t_acc);
        int   b;
        exp_t e;
        @(negedge clk);
        if_req_valid = 1'b1;
        if_addr      = a;
        #1;
        b = 0;
        while (!if_req_ready && b < 20) begin
            @(negedge clk);
            #1;
            b++;
        end
        check("fetch accepted", {31'd0, if_req_ready}, 1);
        t_acc = cyc;
        if (if_req_ready) begin
            e.data = expv;
            e.cyc  = cyc + 4;
            q_f.push_back(e);
        end
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [15:0] a, input logic [7:0] wd,
                           input logic [7:0] expv, output int t_acc);
        int   b;
        exp_t e;
        @(negedge clk);
        d_req_valid = 1'b1;
        d_we        = we;
        d_addr      = a;
        d_wdata     = wd;
        #1;
        b = 0;
        while (!d_req_ready && b < 20) begin
            @(negedge clk);
            #1;
            b++;
        end
        check("data accepted", {31'd0, d_req_ready}, 1);
        t_acc = cyc;
        if (d_req_ready) begin
            if (!we) last_d = expv;
            e.data = {8'd0, last_d};   // store ack leaves d_rsp_data unchanged
            e.cyc  = cyc + (we ? 2 : 3);
            q_d.push_back(e);
        end
        @(posedge clk);
        #1;
        d_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        do begin
            @(negedge clk);
            #1;
            b++;
        end while ((busy || q_f.size() != 0 || q_d.size() != 0) && b < 40);
        check("idle reached", {31'd0, busy}, 0);
        check("scoreboard drained", q_f.size() + q_d.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int         t1, t2, td;
        logic [1:0] g_exp [3];

`ifdef MEM_ARB_RR_EN
        g_exp[0] = 2'b10; g_exp[1] = 2'b01; g_exp[2] = 2'b10;
`else
        g_exp[0] = 2'b01; g_exp[1] = 2'b01; g_exp[2] = 2'b01;
`endif
        mem[16'h0010] = 8'h34;
        mem[16'h0011] = 8'h12;
        mem[16'hFFFF] = 8'hAB;
        mem[16'h0000] = 8'hCD;
        if_req_valid  = 1'b0;
        d_req_valid   = 1'b0;
        if_addr       = '0;
        d_addr        = '0;
        d_we          = 1'b0;
        d_wdata       = '0;
        rst_n         = 1'b0;

        do_reset(3);

        // Basic fetch and address wrap
        do_fetch(16'h0010, 16'h1234, t1);
        wait_idle();
        do_fetch(16'hFFFF, 16'hCDAB, t1);
        wait_idle();

        // Store then load back
        td = we_cnt;
        do_data(1'b1, 16'h0200, 8'h5A, 8'h00, t1);
        wait_idle();
        check("store mem_we cycles", we_cnt - td, 1);
        check("store in memory", {24'd0, mem[16'h0200]}, 32'h5A);
        do_data(1'b0, 16'h0200, 8'h00, 8'h5A, t1);
        wait_idle();

        // Back-to-back throughput
        do_fetch(16'h0010, 16'h1234, t1);
        do_fetch(16'hFFFF, 16'hCDAB, t2);
        check("fetch spacing", t2 - t1, 4);
        wait_idle();
        do_data(1'b0, 16'h0200, 8'h00, 8'h5A, t1);
        do_data(1'b0, 16'h0010, 8'h00, 8'h34, t2);
        check("load spacing", t2 - t1, 3);
        wait_idle();

        // Conflicts from a fresh reset (arbitration pointer cleared)
        do_reset(2);
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            @(negedge clk);
            if_req_valid = 1'b1;
            if_addr      = 16'h0010;
            d_req_valid  = 1'b1;
            d_we         = 1'b0;
            d_addr       = 16'h0200;
            #1;
            check($sformatf("conflict grant %0d", i), {30'd0, if_req_ready, d_req_ready},
                  {30'd0, g_exp[i]});
            if (if_req_ready) begin
                e.data = 16'h1234;
                e.cyc  = cyc + 4;
                q_f.push_back(e);
            end else if (d_req_ready) begin
                last_d = 8'h5A;
                e.data = 16'h005A;
                e.cyc  = cyc + 3;
                q_d.push_back(e);
            end
            @(posedge clk);
            #1;
            if_req_valid = 1'b0;
            d_req_valid  = 1'b0;
            wait_idle();
        end

        // Reset during F_HI drops the fetch
        @(negedge clk);
        if_req_valid = 1'b1;
        if_addr      = 16'h0010;
        #1;
        check("abort fetch accepted", {31'd0, if_req_ready}, 1);
        @(posedge clk);
        #1;
        if_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("in F_HI", {15'd0, mem_en, mem_addr}, {15'd0, 1'b1, 16'h0011});
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check("post-rst outputs", {if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid,
                                   mem_en, mem_we, busy}, 0);
        check("post-rst mem bus", {mem_addr, mem_wdata}, 0);
        check("post-rst rsp data", {8'd0, if_rsp_data, d_rsp_data}, 0);
        rst_n  = 1'b1;
        last_d = 8'h00;
        for (int i = 0; i < 4; i++) begin
            check("no rsp after abort", {30'd0, if_rsp_valid, busy}, 0);
            @(negedge clk);
            #1;
        end

        do_fetch(16'h0010, 16'h1234, t1);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
